// File: rtl/ascon_serial_loader.sv
// ----------------------------------------------------------------------------
// ascon_serial_loader
//
// Upstream feeder for the bit-serial ascon core. A job (key, nonce, associated
// data, text, reference tag and mode) is taken in one valid/ready handshake.
// Each field is then shifted MSB-first onto its own serial line. After that the
// encryption or decryption start strobe is held for START_CYCLES cycles. The
// loader then waits for the core to report completion before accepting the
// next job.
//
// Ports
//   clk             : sole clock, rising edge
//   rst             : synchronous active-high reset
//   in_valid        : job present on the parallel inputs
//   in_ready        : loader idle, job will be accepted this cycle
//   mode            : 0 = encrypt, 1 = decrypt (latched on accept)
//   key_in          : key, k bits
//   nonce_in        : nonce, 128 bits
//   ad_in           : associated data, A_l bits
//   text_in         : plaintext / ciphertext, text_l bits
//   tag_ref         : reference tag, 128 bits (shifted in both modes)
//   core_done       : completion flag from the core
//   key_SI .. tag_in: serial data lines to the core
//   encryption_s_SI : encrypt start strobe
//   decryption_s_SI : decrypt start strobe
//   busy            : inverse of in_ready
//   job_done        : one-cycle pulse after the core reports completion
// ----------------------------------------------------------------------------
module ascon_serial_loader #(
  parameter int k            = 128,
  parameter int A_l          = 112,
  parameter int text_l       = 128,
  parameter int START_CYCLES = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mode,
  input  logic [k-1:0]      key_in,
  input  logic [127:0]      nonce_in,
  input  logic [A_l-1:0]    ad_in,
  input  logic [text_l-1:0] text_in,
  input  logic [127:0]      tag_ref,
  input  logic              core_done,
  output logic              key_SI,
  output logic              nonce_SI,
  output logic              associated_SI,
  output logic              plaintext_SI,
  output logic              tag_in,
  output logic              encryption_s_SI,
  output logic              decryption_s_SI,
  output logic              busy,
  output logic              job_done
);

  // The shift length is the widest field; nonce and tag are fixed at 128 bits.
  localparam int MAX_KA  = (k > A_l) ? k : A_l;
  localparam int MAX_KAT = (MAX_KA > text_l) ? MAX_KA : text_l;
  localparam int MAX     = (MAX_KAT > 128) ? MAX_KAT : 128;

  localparam int CNT_W  = $clog2(MAX + 1);
  localparam int SCNT_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

  localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(MAX - 1);
  localparam logic [SCNT_W-1:0] LAST_START = SCNT_W'(START_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_START,
    S_WAIT
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [k-1:0]      r_key;
  logic [127:0]      r_nonce;
  logic [A_l-1:0]    r_ad;
  logic [text_l-1:0] r_text;
  logic [127:0]      r_tag;
  logic              r_mode;
  logic [CNT_W-1:0]  r_bitCnt;
  logic [SCNT_W-1:0] r_startCnt;
  logic              r_jobDone;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Datapath: field shift registers, counters and the completion pulse.
  // Fields shift left with zero fill, so a field narrower than MAX drives 0
  // once exhausted without any per-field comparison.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key      <= '0;
      r_nonce    <= '0;
      r_ad       <= '0;
      r_text     <= '0;
      r_tag      <= '0;
      r_mode     <= 1'b0;
      r_bitCnt   <= '0;
      r_startCnt <= '0;
      r_jobDone  <= 1'b0;
    end else begin
      r_jobDone <= (r_state == S_WAIT) && core_done;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_key    <= key_in;
            r_nonce  <= nonce_in;
            r_ad     <= ad_in;
            r_text   <= text_in;
            r_tag    <= tag_ref;
            r_mode   <= mode;
            r_bitCnt <= '0;
          end
        end
        S_SHIFT: begin
          r_key      <= {r_key[k-2:0], 1'b0};
          r_nonce    <= {r_nonce[126:0], 1'b0};
          r_ad       <= {r_ad[A_l-2:0], 1'b0};
          r_text     <= {r_text[text_l-2:0], 1'b0};
          r_tag      <= {r_tag[126:0], 1'b0};
          r_bitCnt   <= r_bitCnt + CNT_W'(1);
          // Keeps the strobe counter at zero on entry to START.
          r_startCnt <= '0;
        end
        S_START: begin
          r_startCnt <= r_startCnt + SCNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state and output decode. All outputs come from state and registers,
  // so in_ready has no combinational path from in_valid.
  always_comb begin
    w_nextState     = r_state;
    in_ready        = 1'b0;
    key_SI          = 1'b0;
    nonce_SI        = 1'b0;
    associated_SI   = 1'b0;
    plaintext_SI    = 1'b0;
    tag_in          = 1'b0;
    encryption_s_SI = 1'b0;
    decryption_s_SI = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_nextState = S_SHIFT;
        end
      end
      S_SHIFT: begin
        key_SI        = r_key[k-1];
        nonce_SI      = r_nonce[127];
        associated_SI = r_ad[A_l-1];
        plaintext_SI  = r_text[text_l-1];
        tag_in        = r_tag[127];
        if (r_bitCnt == LAST_BIT) begin
          w_nextState = S_START;
        end
      end
      S_START: begin
        encryption_s_SI = ~r_mode;
        decryption_s_SI = r_mode;
        if (r_startCnt == LAST_START) begin
          w_nextState = S_WAIT;
        end
      end
      S_WAIT: begin
        if (core_done) begin
          w_nextState = S_IDLE;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  assign busy     = ~in_ready;
  assign job_done = r_jobDone;

endmodule

// File: tb/tb_ascon_serial_loader.sv
// ----------------------------------------------------------------------------
// tb_ascon_serial_loader
//
// Self-checking bench for ascon_serial_loader. A default-width instance covers
// encrypt, decrypt, completion, back-to-back, reset abort and random jobs. A
// second instance with 40-bit AD/text covers the narrow-field corner.
// ----------------------------------------------------------------------------
module tb_ascon_serial_loader;

  localparam int MAXL = 128;
  localparam int SC   = 5;

  int checks;
  int failures;

  logic clk = 1'b0;
  logic rst;

  // Default-width instance signals.
  logic         inValid, inReady, mode, coreDone;
  logic [127:0] keyIn, nonceIn, textIn, tagRef;
  logic [111:0] adIn;
  logic         keySI, nonceSI, adSI, ptSI, tagSI, encS, decS, busy, jobDone;

  // Narrow-field instance signals.
  logic         cInValid, cInReady, cMode, cCoreDone;
  logic [127:0] cKeyIn, cNonceIn, cTagRef;
  logic [39:0]  cAdIn, cTextIn;
  logic         cKeySI, cNonceSI, cAdSI, cPtSI, cTagSI, cEncS, cDecS, cBusy, cJobDone;

  // Values captured by applyStimulus for the most recent job.
  logic [127:0] capKey, capNonce, capAd, capText, capTag;
  int           encCount, decCount, encFirst, decFirst;
  int           serialLate, readyDuring, doneCycle;
  logic         readyAtDone, timedOut;

  // Job presented on the inputs right after an accept when in_valid is kept high.
  logic         nxtMode;
  logic [127:0] nxtKey, nxtNonce, nxtText, nxtTag;
  logic [111:0] nxtAd;

  always #5 clk = ~clk;

  ascon_serial_loader dut (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady), .mode(mode),
    .key_in(keyIn), .nonce_in(nonceIn), .ad_in(adIn), .text_in(textIn),
    .tag_ref(tagRef), .core_done(coreDone),
    .key_SI(keySI), .nonce_SI(nonceSI), .associated_SI(adSI),
    .plaintext_SI(ptSI), .tag_in(tagSI),
    .encryption_s_SI(encS), .decryption_s_SI(decS),
    .busy(busy), .job_done(jobDone)
  );

  ascon_serial_loader #(.k(128), .A_l(40), .text_l(40), .START_CYCLES(5)) dutW (
    .clk(clk), .rst(rst), .in_valid(cInValid), .in_ready(cInReady), .mode(cMode),
    .key_in(cKeyIn), .nonce_in(cNonceIn), .ad_in(cAdIn), .text_in(cTextIn),
    .tag_ref(cTagRef), .core_done(cCoreDone),
    .key_SI(cKeySI), .nonce_SI(cNonceSI), .associated_SI(cAdSI),
    .plaintext_SI(cPtSI), .tag_in(cTagSI),
    .encryption_s_SI(cEncS), .decryption_s_SI(cDecS),
    .busy(cBusy), .job_done(cJobDone)
  );

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Presents one job, then records every serial bit, strobe timing and the
  // completion cycle relative to the accept edge (cycle 0 follows that edge).
  // core_done is raised doneAt cycles into WAIT; with earlyDone it also pulses
  // three cycles into START, where it must be ignored.
  task automatic applyStimulus(input logic m, input logic [127:0] kv, input logic [127:0] nv,
                               input logic [111:0] av, input logic [127:0] tv,
                               input logic [127:0] gv, input int doneAt,
                               input logic earlyDone, input logic keepValid);
    keyIn = kv; nonceIn = nv; adIn = av; textIn = tv; tagRef = gv; mode = m;
    inValid = 1'b1;
    capKey = '0; capNonce = '0; capAd = '0; capText = '0; capTag = '0;
    encCount = 0; decCount = 0; encFirst = -1; decFirst = -1;
    serialLate = 0; readyDuring = 0; doneCycle = -1; readyAtDone = 1'b0;
    timedOut = 1'b1;
    @(posedge clk); #1;
    if (keepValid) begin
      keyIn = nxtKey; nonceIn = nxtNonce; adIn = nxtAd; textIn = nxtText;
      tagRef = nxtTag; mode = nxtMode;
    end else begin
      inValid = 1'b0;
      keyIn = rand128(); nonceIn = rand128(); adIn = 112'(rand128());
      textIn = rand128(); tagRef = rand128(); mode = ~m;
    end
    for (int c = 0; c < MAXL + SC + doneAt + 20; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      if (jobDone) begin
        doneCycle = c; readyAtDone = inReady; timedOut = 1'b0; coreDone = 1'b0;
        break;
      end
      if (c < MAXL) begin
        capKey[MAXL-1-c] = keySI; capNonce[MAXL-1-c] = nonceSI; capAd[MAXL-1-c] = adSI;
        capText[MAXL-1-c] = ptSI; capTag[MAXL-1-c] = tagSI;
      end else if (keySI | nonceSI | adSI | ptSI | tagSI) begin
        serialLate++;
      end
      if (encS) begin
        if (encCount == 0) encFirst = c;
        encCount++;
      end
      if (decS) begin
        if (decCount == 0) decFirst = c;
        decCount++;
      end
      if (inReady || !busy) readyDuring++;
      coreDone = (earlyDone && (c == MAXL + 3)) || (c == MAXL + SC + doneAt);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (inReady !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=1", inReady); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if ({keySI, nonceSI, adSI, ptSI, tagSI, encS, decS, jobDone} !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%b exp=00000000", {keySI, nonceSI, adSI, ptSI, tagSI, encS, decS, jobDone});
    end
  endtask

  task automatic test_encrypt_vectors();
    logic [127:0] kv, tv, gv;
    logic [111:0] av;
    kv = 128'h000102030405060708090a0b0c0d0e0f;
    av = 112'h000102030405060708090a0b0c0d;
    tv = 128'h000102030405060708090a0b0c0d0e0f;
    gv = rand128();
    applyStimulus(1'b0, kv, kv, av, tv, gv, 20, 1'b0, 1'b0);
    checks++; if (capKey !== kv) begin failures++; $display("[TB] FAIL enc_key got=%h exp=%h", capKey, kv); end
    checks++; if (capNonce !== kv) begin failures++; $display("[TB] FAIL enc_nonce got=%h exp=%h", capNonce, kv); end
    checks++; if (capAd !== {av, 16'h0}) begin failures++; $display("[TB] FAIL enc_ad got=%h exp=%h", capAd, {av, 16'h0}); end
    checks++; if (capAd[15:0] !== 16'h0) begin failures++; $display("[TB] FAIL enc_ad_tail got=%h exp=0000", capAd[15:0]); end
    checks++; if (capText !== tv) begin failures++; $display("[TB] FAIL enc_text got=%h exp=%h", capText, tv); end
    checks++; if (capTag !== gv) begin failures++; $display("[TB] FAIL enc_tag got=%h exp=%h", capTag, gv); end
    checks++; if (encCount !== SC) begin failures++; $display("[TB] FAIL enc_strobe_len got=%0d exp=%0d", encCount, SC); end
    checks++; if (encFirst !== MAXL) begin failures++; $display("[TB] FAIL enc_strobe_start got=%0d exp=%0d", encFirst, MAXL); end
    checks++; if (decCount !== 0) begin failures++; $display("[TB] FAIL enc_no_dec got=%0d exp=0", decCount); end
    checks++; if (serialLate !== 0) begin failures++; $display("[TB] FAIL enc_serial_idle got=%0d exp=0", serialLate); end
    checks++; if (readyDuring !== 0) begin failures++; $display("[TB] FAIL enc_ready_low got=%0d exp=0", readyDuring); end
    checks++; if (doneCycle !== MAXL + SC + 21) begin failures++; $display("[TB] FAIL enc_done_cycle got=%0d exp=%0d", doneCycle, MAXL + SC + 21); end
  endtask

  task automatic test_decrypt();
    logic [127:0] kv, nv, tv, gv;
    logic [111:0] av;
    kv = rand128(); nv = rand128(); av = 112'(rand128()); tv = rand128();
    gv = 128'h526e4b15b4b3184a2fc1f7d160e4e972;
    applyStimulus(1'b1, kv, nv, av, tv, gv, 5, 1'b0, 1'b0);
    checks++; if (capTag !== gv) begin failures++; $display("[TB] FAIL dec_tag got=%h exp=%h", capTag, gv); end
    checks++; if (capText !== tv) begin failures++; $display("[TB] FAIL dec_text got=%h exp=%h", capText, tv); end
    checks++; if (decCount !== SC) begin failures++; $display("[TB] FAIL dec_strobe_len got=%0d exp=%0d", decCount, SC); end
    checks++; if (decFirst !== MAXL) begin failures++; $display("[TB] FAIL dec_strobe_start got=%0d exp=%0d", decFirst, MAXL); end
    checks++; if (encCount !== 0) begin failures++; $display("[TB] FAIL dec_no_enc got=%0d exp=0", encCount); end
    checks++; if (timedOut !== 1'b0) begin failures++; $display("[TB] FAIL dec_timeout got=%b exp=0", timedOut); end
  endtask

  task automatic test_completion();
    applyStimulus(1'b0, rand128(), rand128(), 112'(rand128()), rand128(), rand128(), 20, 1'b1, 1'b0);
    checks++; if (doneCycle !== MAXL + SC + 21) begin failures++; $display("[TB] FAIL done_cycle got=%0d exp=%0d", doneCycle, MAXL + SC + 21); end
    checks++; if (readyAtDone !== 1'b1) begin failures++; $display("[TB] FAIL done_ready got=%b exp=1", readyAtDone); end
    @(posedge clk); #1;
    checks++; if (jobDone !== 1'b0) begin failures++; $display("[TB] FAIL done_pulse_width got=%b exp=0", jobDone); end
    checks++; if (inReady !== 1'b1) begin failures++; $display("[TB] FAIL done_idle got=%b exp=1", inReady); end
  endtask

  task automatic test_random_jobs();
    logic         m;
    logic [127:0] kv, nv, tv, gv;
    logic [111:0] av;
    int           dAt;
    for (int j = 0; j < 3; j++) begin
      m = 1'($urandom_range(1, 0)); kv = rand128(); nv = rand128();
      av = 112'(rand128()); tv = rand128(); gv = rand128();
      dAt = $urandom_range(30, 0);
      applyStimulus(m, kv, nv, av, tv, gv, dAt, 1'b0, 1'b0);
      checks++;
      if ({capKey, capNonce, capAd, capText, capTag} !== {kv, nv, av, 16'h0, tv, gv}) begin
        failures++; $display("[TB] FAIL rand_fields job=%0d got=%h %h exp=%h %h", j, capKey, capAd, kv, {av, 16'h0});
      end
      checks++;
      if ((m ? decCount : encCount) !== SC || (m ? encCount : decCount) !== 0) begin
        failures++; $display("[TB] FAIL rand_strobe job=%0d got=enc%0d dec%0d exp_mode=%b", j, encCount, decCount, m);
      end
      checks++;
      if (doneCycle !== MAXL + SC + dAt + 1) begin
        failures++; $display("[TB] FAIL rand_done job=%0d got=%0d exp=%0d", j, doneCycle, MAXL + SC + dAt + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] kv, nv, tv, gv;
    logic [111:0] av;
    kv = rand128(); nv = rand128(); av = 112'(rand128()); tv = rand128(); gv = rand128();
    nxtKey = rand128(); nxtNonce = rand128(); nxtAd = 112'(rand128());
    nxtText = rand128(); nxtTag = rand128(); nxtMode = 1'b1;
    applyStimulus(1'b0, kv, nv, av, tv, gv, 0, 1'b0, 1'b1);
    checks++; if (capKey !== kv || capText !== tv) begin failures++; $display("[TB] FAIL b2b_job1 got=%h exp=%h", capKey, kv); end
    checks++; if (readyDuring !== 0) begin failures++; $display("[TB] FAIL b2b_early_accept got=%0d exp=0", readyDuring); end
    checks++; if (readyAtDone !== 1'b1 || doneCycle !== MAXL + SC + 1) begin
      failures++; $display("[TB] FAIL b2b_done got=%b@%0d exp=1@%0d", readyAtDone, doneCycle, MAXL + SC + 1);
    end
    applyStimulus(nxtMode, nxtKey, nxtNonce, nxtAd, nxtText, nxtTag, 3, 1'b0, 1'b0);
    checks++; if (readyDuring !== 0) begin failures++; $display("[TB] FAIL b2b_accept2 got=%0d exp=0", readyDuring); end
    checks++;
    if ({capKey, capNonce, capAd, capText, capTag} !== {nxtKey, nxtNonce, nxtAd, 16'h0, nxtText, nxtTag}) begin
      failures++; $display("[TB] FAIL b2b_job2 got=%h %h exp=%h %h", capKey, capTag, nxtKey, nxtTag);
    end
    checks++; if (decCount !== SC || encCount !== 0) begin failures++; $display("[TB] FAIL b2b_mode2 got=enc%0d dec%0d exp=enc0 dec5", encCount, decCount); end
  endtask

  task automatic test_reset_abort();
    logic [127:0] kv;
    int           activity;
    kv = rand128();
    keyIn = kv; nonceIn = rand128(); adIn = 112'(rand128()); textIn = rand128();
    tagRef = rand128(); mode = 1'b0; inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
    end
    checks++; if (keySI !== kv[127-60]) begin failures++; $display("[TB] FAIL abort_bit60 got=%b exp=%b", keySI, kv[127-60]); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({keySI, nonceSI, adSI, ptSI, tagSI, encS, decS, jobDone} !== 8'h00) begin
      failures++; $display("[TB] FAIL abort_outputs got=%b exp=00000000", {keySI, nonceSI, adSI, ptSI, tagSI, encS, decS, jobDone});
    end
    checks++; if (inReady !== 1'b1 || busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_ready got=%b/%b exp=1/0", inReady, busy); end
    rst = 1'b0;
    activity = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (jobDone | encS | decS | keySI | tagSI | ~inReady) activity++;
    end
    checks++; if (activity !== 0) begin failures++; $display("[TB] FAIL abort_quiet got=%0d exp=0", activity); end
    kv = rand128();
    applyStimulus(1'b1, kv, rand128(), 112'(rand128()), rand128(), 128'h526e4b15b4b3184a2fc1f7d160e4e972, 2, 1'b0, 1'b0);
    checks++; if (capKey !== kv || capTag !== 128'h526e4b15b4b3184a2fc1f7d160e4e972) begin
      failures++; $display("[TB] FAIL abort_rerun got=%h exp=%h", capKey, kv);
    end
    checks++; if (decCount !== SC || timedOut !== 1'b0) begin failures++; $display("[TB] FAIL abort_rerun_ctl got=dec%0d to%b exp=dec5 to0", decCount, timedOut); end
  endtask

  task automatic test_width_corner();
    logic [127:0] kv, wAd, wText, wKey;
    logic [39:0]  av, tv;
    int           enc, first;
    kv = rand128(); av = 40'(rand128()); tv = 40'(rand128());
    wAd = '0; wText = '0; wKey = '0; enc = 0; first = -1;
    cKeyIn = kv; cNonceIn = rand128(); cAdIn = av; cTextIn = tv; cTagRef = rand128();
    cMode = 1'b0; cInValid = 1'b1;
    @(posedge clk); #1;
    cInValid = 1'b0;
    for (int c = 0; c < MAXL + SC + 2; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      if (c < MAXL) begin
        wKey[MAXL-1-c] = cKeySI; wAd[MAXL-1-c] = cAdSI; wText[MAXL-1-c] = cPtSI;
      end
      if (cEncS) begin
        if (enc == 0) first = c;
        enc++;
      end
    end
    checks++; if (wKey !== kv) begin failures++; $display("[TB] FAIL corner_key got=%h exp=%h", wKey, kv); end
    checks++; if (wAd !== {av, 88'h0}) begin failures++; $display("[TB] FAIL corner_ad got=%h exp=%h", wAd, {av, 88'h0}); end
    checks++; if (wText !== {tv, 88'h0}) begin failures++; $display("[TB] FAIL corner_text got=%h exp=%h", wText, {tv, 88'h0}); end
    checks++; if (first !== MAXL || enc !== SC) begin failures++; $display("[TB] FAIL corner_shift_len got=%0d/%0d exp=%0d/%0d", first, enc, MAXL, SC); end
  endtask

  // Hard bound on the whole run.
  initial begin
    #500000;
    $display("[TB] FAIL global_timeout got=running exp=finished");
    $fatal(1, "[TB] timeout");
  end

  // Test sequence.
  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; inValid = 1'b0; coreDone = 1'b0; mode = 1'b0;
    keyIn = '0; nonceIn = '0; adIn = '0; textIn = '0; tagRef = '0;
    cInValid = 1'b0; cCoreDone = 1'b0; cMode = 1'b0;
    cKeyIn = '0; cNonceIn = '0; cAdIn = '0; cTextIn = '0; cTagRef = '0;
    nxtMode = 1'b0; nxtKey = '0; nxtNonce = '0; nxtAd = '0; nxtText = '0; nxtTag = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_encrypt_vectors();
    @(posedge clk); #1;
    test_decrypt();
    @(posedge clk); #1;
    test_completion();
    test_random_jobs();
    @(posedge clk); #1;
    test_back_to_back();
    @(posedge clk); #1;
    test_reset_abort();
    @(posedge clk); #1;
    test_width_corner();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
